// File: rtl/axi_ddr_read_ctrl.sv
// AXI4 read front end for the DDR4 controller: buffers AR requests, expands bursts into
// per-beat DDR read commands under a return-buffer credit limit, and returns data in order on R.

module axi_ddr_read_ctrl_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             aclk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;
   logic             do_push, do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   // NOTE: storage is not reset; the reset pointers/count guarantee stale words are never presented as valid.
   always_ff @(posedge aclk)
      if (do_push) mem[wr_ptr] <= din;

   always_ff @(posedge aclk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      end
   end
endmodule

module axi_ddr_read_ctrl #(
   parameter int DATAWIDTH = 128,
   parameter int IDWIDTH   = 3,
   parameter int ADDRSIZE  = 34,
   parameter int AR_DEPTH  = 4,
   parameter int RDQ_DEPTH = 8
) (
   input  logic                 aclk,
   input  logic                 rst_n,
   input  logic                 arvalid,
   input  logic [IDWIDTH-1:0]   arid,
   input  logic [ADDRSIZE-1:0]  araddr,
   input  logic [7:0]           arlen,
   input  logic [2:0]           arsize,
   input  logic [1:0]           arburst,
   output logic                 arready,
   output logic                 rvalid,
   input  logic                 rready,
   output logic [DATAWIDTH-1:0] rdata,
   output logic [IDWIDTH-1:0]   rid,
   output logic [1:0]           rresp,
   output logic                 rlast,
   output logic                 rd_cmd_valid,
   input  logic                 rd_cmd_ready,
   output logic [ADDRSIZE-1:0]  rd_cmd_addr,
   input  logic                 rd_data_valid,
   input  logic [DATAWIDTH-1:0] rd_data,
   input  logic                 rd_data_err,
   output logic                 busy
);
   localparam int                ARW      = IDWIDTH + ADDRSIZE + 8 + 3 + 2;
   localparam int                OW       = $clog2(RDQ_DEPTH) + 1;
   localparam logic [OW-1:0]     CREDITS  = RDQ_DEPTH[OW-1:0];
   localparam logic [2:0]        MAX_SIZE = 3'($clog2(DATAWIDTH/8));
   localparam logic [ADDRSIZE-1:0] ONE    = ADDRSIZE'(1);

   typedef enum logic {IDLE, BURST} state_t;
   typedef enum logic [1:0] {MODE_FIXED, MODE_INCR, MODE_WRAP} mode_t;

   state_t               state, next_state;
   mode_t                mode, q_mode;
   logic                 ar_en, ar_avail_q, ar_avail, ar_pop, ar_full, ar_empty;
   logic [ARW-1:0]       ar_dout;
   logic [IDWIDTH-1:0]   q_id, b_id, m_id;
   logic [ADDRSIZE-1:0]  q_addr, addr, next_addr, bytes, aligned, incr_addr, wrap_len;
   logic [7:0]           q_len, b_len, beat_cnt;
   logic [2:0]           q_size, b_size;
   logic [1:0]           q_burst;
   logic [OW-1:0]        outstanding;
   logic                 cmd_fire, r_fire, last_beat, m_last, meta_empty, meta_full;
   logic                 dq_empty, dq_full, d_err;
   logic [DATAWIDTH-1:0] d_data;
   logic                 unused_ok;

   assign arready = ar_en && !ar_full;
   // Availability is qualified by a registered copy so a fresh AR spends one extra cycle in the FIFO.
   assign ar_avail = ar_avail_q && !ar_empty;
   assign {q_id, q_addr, q_len, q_size, q_burst} = ar_dout;

   axi_ddr_read_ctrl_fifo #(.WIDTH(ARW), .DEPTH(AR_DEPTH)) u_ar_fifo (
      .aclk(aclk), .rst_n(rst_n), .push(arvalid && arready),
      .din({arid, araddr, arlen, arsize, arburst}), .pop(ar_pop),
      .dout(ar_dout), .full(ar_full), .empty(ar_empty));

   always_comb begin
      q_mode = MODE_INCR;
      if (q_burst == 2'b00)
         q_mode = MODE_FIXED;
      else if (q_burst == 2'b10 && (q_len == 8'd1 || q_len == 8'd3 || q_len == 8'd7 || q_len == 8'd15))
         q_mode = MODE_WRAP;
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      next_state   = state;
      ar_pop       = 1'b0;
      rd_cmd_valid = 1'b0;
      case (state)
         IDLE: if (ar_avail) begin
            ar_pop     = 1'b1;
            next_state = BURST;
         end
         BURST: begin
            rd_cmd_valid = (outstanding < CREDITS);
            if ((outstanding < CREDITS) && rd_cmd_ready && last_beat) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   assign cmd_fire  = rd_cmd_valid && rd_cmd_ready;
   assign last_beat = (beat_cnt == b_len);

   always_comb begin
      bytes     = ONE << b_size;
      aligned   = addr & ~(bytes - ONE);
      incr_addr = aligned + bytes;
      wrap_len  = (ADDRSIZE'(b_len) + ONE) << b_size;
      next_addr = incr_addr;
      case (mode)
         MODE_FIXED: next_addr = addr;
         MODE_WRAP:  if ((incr_addr & (wrap_len - ONE)) == '0) next_addr = incr_addr - wrap_len;
         default:    next_addr = incr_addr;
      endcase
   end

   always_ff @(posedge aclk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         ar_en       <= 1'b0;
         ar_avail_q  <= 1'b0;
         mode        <= MODE_INCR;
         b_id        <= '0;
         b_len       <= '0;
         b_size      <= '0;
         addr        <= '0;
         beat_cnt    <= '0;
         outstanding <= '0;
      end else begin
         state      <= next_state;
         ar_en      <= 1'b1;
         ar_avail_q <= !ar_empty;
         if (ar_pop) begin
            b_id     <= q_id;
            b_len    <= q_len;
            b_size   <= (q_size > MAX_SIZE) ? MAX_SIZE : q_size;
            mode     <= q_mode;
            addr     <= q_addr;
            beat_cnt <= '0;
         end else if (cmd_fire) begin
            addr     <= next_addr;
            beat_cnt <= beat_cnt + 8'd1;
         end
         case ({cmd_fire, r_fire})
            2'b10:   outstanding <= outstanding + OW'(1);
            2'b01:   outstanding <= outstanding - OW'(1);
            default: outstanding <= outstanding;
         endcase
      end
   end

   assign rd_cmd_addr = addr;

   axi_ddr_read_ctrl_fifo #(.WIDTH(IDWIDTH + 1), .DEPTH(RDQ_DEPTH)) u_meta_fifo (
      .aclk(aclk), .rst_n(rst_n), .push(cmd_fire), .din({b_id, last_beat}), .pop(r_fire),
      .dout({m_id, m_last}), .full(meta_full), .empty(meta_empty));

   // Return data with nothing outstanding is stray and dropped.
   axi_ddr_read_ctrl_fifo #(.WIDTH(DATAWIDTH + 1), .DEPTH(RDQ_DEPTH)) u_data_fifo (
      .aclk(aclk), .rst_n(rst_n), .push(rd_data_valid && (outstanding != '0)),
      .din({rd_data, rd_data_err}), .pop(r_fire),
      .dout({d_data, d_err}), .full(dq_full), .empty(dq_empty));

   assign rvalid    = !dq_empty;
   assign r_fire    = rvalid && rready;
   assign rdata     = rvalid ? d_data : '0;
   assign rid       = rvalid ? m_id : '0;
   assign rlast     = rvalid && m_last;
   assign rresp     = (rvalid && d_err) ? 2'b10 : 2'b00;
   assign busy      = (state == BURST) || !ar_empty || !meta_empty;
   assign unused_ok = &{1'b0, meta_full, dq_full};
endmodule
